// File: rtl/tinyproc_pkg.sv
// Shared defaults and types for the tinyproc data-memory path.
package tinyproc_pkg;

  localparam int ADDR_WIDTH_DEF   = 8;
  localparam int DATA_WIDTH_DEF   = 8;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int STARVE_CNT_W     = 4;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_CORE = 2'd1,
    SEL_HOST = 2'd2
  } sel_e;

endpackage

// File: rtl/dmem_ram.sv
// Single-port data RAM: synchronous write, registered read, array not reset.
module dmem_ram #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  en_i,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  // Power-up contents are zero; nothing clears the array afterwards.
  logic [DATA_WIDTH-1:0] mem_q [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en_i) begin
      if (we_i) mem_q[addr_i] <= wdata_i;
      else      rdata_q       <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_arbiter.sv
// Core/host arbiter in front of a single-port data RAM, with host starvation override.
module dmem_arbiter
  import tinyproc_pkg::*;
#(
  parameter int ADDR_WIDTH   = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic                  core_gnt,
  output logic                  core_rvalid,
  output logic [DATA_WIDTH-1:0] core_rdata,
  input  logic                  host_req,
  input  logic                  host_we,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [DATA_WIDTH-1:0] host_wdata,
  output logic                  host_gnt,
  output logic                  host_rvalid,
  output logic [DATA_WIDTH-1:0] host_rdata,
  output logic                  starved
);

  logic [STARVE_CNT_W-1:0] starve_q, starve_d;
  logic                    core_rv_q, host_rv_q;
  logic [DATA_WIDTH-1:0]   core_hold_q, host_hold_q;
  logic                    override;
  sel_e                    sel;
  logic                    ram_we;
  logic [ADDR_WIDTH-1:0]   ram_addr;
  logic [DATA_WIDTH-1:0]   ram_wdata, ram_rdata;

  always_comb begin
    override = reset_n && host_req && (starve_q == STARVE_CNT_W'(STARVE_LIMIT));
    core_gnt = reset_n && core_req && !override;
    host_gnt = reset_n && host_req && !core_gnt;
    starved  = override;
    starve_d = starve_q;
    if (!host_req || host_gnt) starve_d = '0;
    else if (core_gnt)         starve_d = starve_q + 1'b1;
  end

  always_comb begin
    sel       = SEL_NONE;
    ram_we    = 1'b0;
    ram_addr  = core_addr;
    ram_wdata = core_wdata;
    if (core_gnt) begin
      sel    = SEL_CORE;
      ram_we = core_we;
    end else if (host_gnt) begin
      sel       = SEL_HOST;
      ram_we    = host_we;
      ram_addr  = host_addr;
      ram_wdata = host_wdata;
    end
  end

  dmem_ram #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .en_i    (sel != SEL_NONE),
    .we_i    (ram_we),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      starve_q    <= '0;
      core_rv_q   <= 1'b0;
      host_rv_q   <= 1'b0;
      core_hold_q <= '0;
      host_hold_q <= '0;
    end else begin
      starve_q  <= starve_d;
      core_rv_q <= core_gnt && !core_we;
      host_rv_q <= host_gnt && !host_we;
      if (core_rv_q) core_hold_q <= ram_rdata;
      if (host_rv_q) host_hold_q <= ram_rdata;
    end
  end

  // The shared RAM read register is steered to whichever side's read it belongs to;
  // each side keeps its own copy so rdata holds between pulses.
  assign core_rvalid = core_rv_q;
  assign host_rvalid = host_rv_q;
  assign core_rdata  = core_rv_q ? ram_rdata : core_hold_q;
  assign host_rdata  = host_rv_q ? ram_rdata : host_hold_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: grant model, reference memory, read-data queues.
module tb_dmem_arbiter;

  localparam int AW = 8;
  localparam int DW = 8;
  localparam int SL = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          core_req, core_we, host_req, host_we;
  logic [AW-1:0] core_addr, host_addr;
  logic [DW-1:0] core_wdata, host_wdata;
  logic          core_gnt, core_rvalid, host_gnt, host_rvalid, starved;
  logic [DW-1:0] core_rdata, host_rdata;

  dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(SL)) dut (
    .clk(clk), .reset_n(reset_n),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .starved(starved)
  );

  always #5 clk = ~clk;

  int errs   = 0;
  int checks = 0;

  logic [DW-1:0] mdl [2**AW];
  logic [DW-1:0] cq[$], hq[$];
  int            m_cnt;
  bit            m_crv, m_hrv, m_cg, m_hg;
  logic [DW-1:0] m_chold, m_hhold;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic core_drv(input bit req, input bit we, input int addr, input int wd);
    core_req = req; core_we = we; core_addr = AW'(addr); core_wdata = DW'(wd);
  endtask

  task automatic host_drv(input bit req, input bit we, input int addr, input int wd);
    host_req = req; host_we = we; host_addr = AW'(addr); host_wdata = DW'(wd);
  endtask

  // One clock cycle: check the cycle's outputs at the falling edge, advance the model,
  // then return 1 time unit after the next rising edge.
  task automatic tick();
    bit ov;
    @(negedge clk);
    if (!reset_n) begin
      m_cnt = 0; m_crv = 0; m_hrv = 0; m_chold = '0; m_hhold = '0;
      cq.delete(); hq.delete();
    end
    ov   = reset_n && host_req && (m_cnt == SL);
    m_cg = reset_n && core_req && !ov;
    m_hg = reset_n && host_req && !m_cg;
    chk("core_gnt", core_gnt, m_cg);
    chk("host_gnt", host_gnt, m_hg);
    chk("starved", starved, ov);
    chk("gnt_sanity", (core_gnt && host_gnt) || (core_gnt && !core_req) || (host_gnt && !host_req), 0);
    chk("core_rvalid", core_rvalid, m_crv);
    if (m_crv) m_chold = cq.pop_front();
    chk("core_rdata", core_rdata, m_chold);
    chk("host_rvalid", host_rvalid, m_hrv);
    if (m_hrv) m_hhold = hq.pop_front();
    chk("host_rdata", host_rdata, m_hhold);
    m_crv = m_cg && !core_we;
    m_hrv = m_hg && !host_we;
    if (m_cg) begin
      if (core_we) mdl[core_addr] = core_wdata;
      else         cq.push_back(mdl[core_addr]);
    end
    if (m_hg) begin
      if (host_we) mdl[host_addr] = host_wdata;
      else         hq.push_back(mdl[host_addr]);
    end
    if (!reset_n || !host_req || m_hg) m_cnt = 0;
    else if (m_cg)                     m_cnt++;
    @(posedge clk); #1;
  endtask

  task automatic contested(input string tag);
    core_drv(1, 0, 8'h01, 0);
    host_drv(1, 0, 8'h02, 0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk(tag, {core_gnt, host_gnt, starved}, (i % 5 == 4) ? 3'b011 : 3'b100);
      tick();
    end
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0);
    tick();
  endtask

  initial begin
    for (int a = 0; a < 2**AW; a++) mdl[a] = '0;
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0);
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    tick();
    tick();
    chk("rst_crdata", core_rdata, 0);
    chk("rst_hrdata", host_rdata, 0);
    reset_n = 1'b1;
    tick();

    // Core write then host read of the same word.
    core_drv(1, 1, 8'h10, 8'h5A); tick();
    core_drv(0, 0, 0, 0);
    host_drv(1, 0, 8'h10, 0);     tick();
    host_drv(0, 0, 0, 0);
    chk("r035_rvalid", host_rvalid, 1);
    chk("r035_rdata", host_rdata, 8'h5A);
    tick();

    contested("r036_pattern");

    // Host streams reads of 0..3 after the core preloads them.
    for (int i = 0; i < 4; i++) begin
      core_drv(1, 1, i, 8'h11 * (i + 1)); tick();
    end
    core_drv(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      host_drv(1, 0, i, 0); tick();
      chk("r037_rvalid", host_rvalid, 1);
      chk("r037_rdata", host_rdata, 8'h11 * (i + 1));
      chk("r037_core_rv", core_rvalid, 0);
    end
    host_drv(0, 0, 0, 0); tick();
    chk("r037_end_rv", host_rvalid, 0);
    chk("r037_hold", host_rdata, 8'h44);

    // Host write followed immediately by a core read of the same word.
    host_drv(1, 1, 8'h20, 8'hFF); tick();
    host_drv(0, 0, 0, 0);
    core_drv(1, 0, 8'h20, 0);     tick();
    core_drv(0, 0, 0, 0);
    chk("r038_rvalid", core_rvalid, 1);
    chk("r038_rdata", core_rdata, 8'hFF);
    tick();

    // Reset lands in a cycle carrying a core read; counter must restart from zero.
    core_drv(1, 0, 8'h20, 0);
    host_drv(1, 0, 8'h21, 0);
    tick(); tick();
    #1 reset_n = 1'b0;
    tick();
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0);
    tick();
    reset_n = 1'b1;
    tick();
    chk("r039_rvalid", core_rvalid, 0);
    contested("r039_pattern");

    // Random traffic; a requester holds its fields until granted.
    for (int n = 0; n < 10000; n++) begin
      if (!core_req || m_cg)
        core_drv($urandom_range(0, 9) < 6, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
      if (!host_req || m_hg)
        host_drv($urandom_range(0, 9) < 5, $urandom_range(0, 1), $urandom_range(0, 255), $urandom_range(0, 255));
      tick();
    end
    core_drv(0, 0, 0, 0);
    host_drv(0, 0, 0, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
